// File: rtl/nvdla_slcg_multi_ctrl.sv
// Second-level clock-gating controller: one idle hold-off FSM per clock channel drives a
// registered ICG enable. Each channel also has a saturating counter of its gated cycles.
module nvdla_slcg_multi_ctrl #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned HOLD_CYC = 8,
  parameter int unsigned PERF_W   = 16
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rst,
  input  logic                      dla_clk_ovr_on_sync,
  input  logic                      global_clk_ovr_on_sync,
  input  logic                      tmc2slcg_disable_clock_gating,
  input  logic [NUM_CH*NUM_SRC-1:0] slcg_en_src,
  input  logic [NUM_CH-1:0]         ch_active,
  input  logic                      perf_clr,
  output logic [NUM_CH-1:0]         cg_en,
  output logic [2*NUM_CH-1:0]       ch_state,
  output logic [PERF_W*NUM_CH-1:0]  gated_cnt
);

  localparam int unsigned HW          = (HOLD_CYC == 0) ? 1 : $clog2(HOLD_CYC + 1);
  localparam int unsigned HoldInitInt = (HOLD_CYC == 0) ? 0 : HOLD_CYC - 1;
  localparam logic [HW-1:0] HoldInit  = HW'(HoldInitInt);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("NUM_CH must be at least 1");
  end
  if (NUM_SRC < 1) begin : g_bad_num_src
    $error("NUM_SRC must be at least 1");
  end
  if (PERF_W < 1) begin : g_bad_perf_w
    $error("PERF_W must be at least 1");
  end
  if (HOLD_CYC > 255) begin : g_bad_hold_cyc
    $error("HOLD_CYC must be in 0..255");
  end

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StHold  = 2'b01,
    StGated = 2'b10
  } state_e;

  logic force_on;
  assign force_on = dla_clk_ovr_on_sync | global_clk_ovr_on_sync |
                    tmc2slcg_disable_clock_gating;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e              state_q, state_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                cg_q;
    logic [PERF_W-1:0]   cnt_q, cnt_d;
    logic                permit;
    logic                wake;

    assign permit = (&slcg_en_src[c*NUM_SRC +: NUM_SRC]) & ~force_on;
    // Any reason to run the clock wins over every gating transition.
    assign wake   = ~permit | ch_active[c];

    // Next-state logic for the idle hold-off FSM and its hold counter.
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      unique case (state_q)
        StRun: begin
          if (!wake) begin
            if (HOLD_CYC == 0) begin
              state_d = StGated;
            end else begin
              state_d = StHold;
              hold_d  = HoldInit;
            end
          end
        end
        StHold: begin
          if (wake) begin
            state_d = StRun;
            hold_d  = '0;
          end else if (hold_q == '0) begin
            state_d = StGated;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        StGated: begin
          if (wake) begin
            state_d = StRun;
          end
        end
        default: begin
          state_d = StRun;
          hold_d  = '0;
        end
      endcase
    end

    // Gated-cycle counter: clear beats increment, saturates at all ones.
    always_comb begin
      cnt_d = cnt_q;
      if (perf_clr) begin
        cnt_d = '0;
      end else if (state_q == StGated && cnt_q != '1) begin
        cnt_d = cnt_q + PERF_W'(1);
      end
    end

    // State, counters and the ICG enable, registered from next state to avoid input glitches.
    always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
        state_q <= StRun;
        hold_q  <= '0;
        cg_q    <= 1'b1;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        cg_q    <= (state_d != StGated);
        cnt_q   <= cnt_d;
      end
    end

    assign cg_en[c]                      = cg_q;
    assign ch_state[2*c +: 2]            = state_q;
    assign gated_cnt[c*PERF_W +: PERF_W] = cnt_q;
  end

endmodule

// File: tb/tb_nvdla_slcg_multi_ctrl.sv
// Directed bench: main instance (HOLD_CYC=8, PERF_W=16), narrow-counter instance (PERF_W=4)
// and zero-hold instance (HOLD_CYC=0), all driven from the same inputs.
module tb_nvdla_slcg_multi_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dla_ovr, glob_ovr, tmc_dis;
  logic [7:0]  src;
  logic [3:0]  act;
  logic        clr;

  logic [3:0]  cg_m, cg_p, cg_z;
  logic [7:0]  st_m, st_p, st_z;
  logic [63:0] gc_m, gc_z;
  logic [15:0] gc_p;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nvdla_slcg_multi_ctrl #(.NUM_CH(4), .NUM_SRC(2), .HOLD_CYC(8), .PERF_W(16)) dut_m (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .dla_clk_ovr_on_sync(dla_ovr),
    .global_clk_ovr_on_sync(glob_ovr), .tmc2slcg_disable_clock_gating(tmc_dis),
    .slcg_en_src(src), .ch_active(act), .perf_clr(clr),
    .cg_en(cg_m), .ch_state(st_m), .gated_cnt(gc_m));

  nvdla_slcg_multi_ctrl #(.NUM_CH(4), .NUM_SRC(2), .HOLD_CYC(8), .PERF_W(4)) dut_p (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .dla_clk_ovr_on_sync(dla_ovr),
    .global_clk_ovr_on_sync(glob_ovr), .tmc2slcg_disable_clock_gating(tmc_dis),
    .slcg_en_src(src), .ch_active(act), .perf_clr(clr),
    .cg_en(cg_p), .ch_state(st_p), .gated_cnt(gc_p));

  nvdla_slcg_multi_ctrl #(.NUM_CH(4), .NUM_SRC(2), .HOLD_CYC(0), .PERF_W(16)) dut_z (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .dla_clk_ovr_on_sync(dla_ovr),
    .global_clk_ovr_on_sync(glob_ovr), .tmc2slcg_disable_clock_gating(tmc_dis),
    .slcg_en_src(src), .ch_active(act), .perf_clr(clr),
    .cg_en(cg_z), .ch_state(st_z), .gated_cnt(gc_z));

  // One clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Idle every channel long enough for all of them to reach GATED (main instance).
  task automatic gate_all();
    act = 4'b0000;
    step(9);
  endtask

  task automatic test_reset();
    rst = 1'b1; dla_ovr = 1'b0; glob_ovr = 1'b0; tmc_dis = 1'b0;
    src = 8'hFF; act = 4'hF; clr = 1'b0;
    step(3);
    total++; if (cg_m !== 4'hF) begin bad++; $display("FAIL reset_cg_en: got %h want f", cg_m); end
    total++; if (st_m !== 8'h00) begin bad++; $display("FAIL reset_state: got %h want 00", st_m); end
    total++; if (gc_m !== 64'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0", gc_m); end
    total++; if (cg_z !== 4'hF) begin bad++; $display("FAIL reset_cg_en_z: got %h want f", cg_z); end
    total++; if (gc_p !== 16'h0) begin bad++; $display("FAIL reset_cnt_p: got %h want 0", gc_p); end
    rst = 1'b0;
  endtask

  task automatic test_gate();
    act = 4'b1110;
    step(1);
    total++; if (st_m !== 8'h01) begin bad++; $display("FAIL gate_hold_entry: got %h want 01", st_m); end
    total++; if (cg_m !== 4'hF) begin bad++; $display("FAIL gate_hold_cg: got %h want f", cg_m); end
    total++; if (cg_z !== 4'hE) begin bad++; $display("FAIL hold0_gate: got %h want e", cg_z); end
    total++; if (st_z !== 8'h02) begin bad++; $display("FAIL hold0_state: got %h want 02", st_z); end
    step(7);
    total++; if (st_m !== 8'h01) begin bad++; $display("FAIL gate_last_hold: got %h want 01", st_m); end
    total++; if (cg_m !== 4'hF) begin bad++; $display("FAIL gate_early: got %h want f", cg_m); end
    step(1);
    total++; if (cg_m !== 4'hE) begin bad++; $display("FAIL gate_cg: got %h want e", cg_m); end
    total++; if (st_m !== 8'h02) begin bad++; $display("FAIL gate_state: got %h want 02", st_m); end
    step(3);
    total++; if (gc_m[15:0] !== 16'd3) begin bad++; $display("FAIL gate_cnt: got %0d want 3", gc_m[15:0]); end
    total++; if (gc_z[15:0] !== 16'd11) begin bad++; $display("FAIL hold0_cnt: got %0d want 11", gc_z[15:0]); end
    total++; if (gc_m[63:16] !== 48'h0) begin bad++; $display("FAIL gate_other_cnt: got %h want 0", gc_m[63:16]); end
  endtask

  task automatic test_wake();
    act = 4'b1111;
    step(1);
    total++; if (cg_m !== 4'hF) begin bad++; $display("FAIL wake_cg: got %h want f", cg_m); end
    total++; if (st_m !== 8'h00) begin bad++; $display("FAIL wake_state: got %h want 00", st_m); end
    act = 4'b1110;
    step(5);
    total++; if (st_m !== 8'h01) begin bad++; $display("FAIL wake_mid_hold: got %h want 01", st_m); end
    act = 4'b1111;
    step(1);
    total++; if (st_m !== 8'h00) begin bad++; $display("FAIL wake_hold_abort: got %h want 00", st_m); end
    act = 4'b1110;
    step(8);
    total++; if (st_m !== 8'h01 || cg_m !== 4'hF) begin
      bad++; $display("FAIL wake_restart_hold: got st=%h cg=%h want st=01 cg=f", st_m, cg_m);
    end
    step(1);
    total++; if (cg_m !== 4'hE) begin bad++; $display("FAIL wake_regate: got %h want e", cg_m); end
  endtask

  task automatic test_override();
    for (int k = 0; k < 3; k++) begin
      gate_all();
      total++; if (cg_m !== 4'h0) begin bad++; $display("FAIL ovr%0d_all_gated: got %h want 0", k, cg_m); end
      glob_ovr = (k == 0); dla_ovr = (k == 1); tmc_dis = (k == 2);
      step(1);
      glob_ovr = 1'b0; dla_ovr = 1'b0; tmc_dis = 1'b0;
      total++; if (cg_m !== 4'hF) begin bad++; $display("FAIL ovr%0d_cg: got %h want f", k, cg_m); end
      total++; if (st_m !== 8'h00) begin bad++; $display("FAIL ovr%0d_state: got %h want 00", k, st_m); end
    end
    gate_all();
    src = 8'hEF;  // ch2 source 0 dropped
    step(1);
    total++; if (cg_m !== 4'b0100) begin bad++; $display("FAIL src_drop_cg: got %h want 4", cg_m); end
    total++; if (st_m !== 8'h8A) begin bad++; $display("FAIL src_drop_state: got %h want 8a", st_m); end
    src = 8'hFF;
    // ch2 reaches HOLD with count 0, then an override lands on the would-be gating edge.
    step(8);
    total++; if (st_m[5:4] !== 2'b01) begin bad++; $display("FAIL prio_pre: got %b want 01", st_m[5:4]); end
    glob_ovr = 1'b1;
    step(1);
    glob_ovr = 1'b0;
    total++; if (cg_m !== 4'hF || st_m !== 8'h00) begin
      bad++; $display("FAIL prio_wake: got cg=%h st=%h want cg=f st=00", cg_m, st_m);
    end
  endtask

  task automatic test_perf();
    rst = 1'b1; act = 4'b1101;
    step(1);
    rst = 1'b0;
    step(9);
    total++; if (cg_p !== 4'hD) begin bad++; $display("FAIL perf_gated: got %h want d", cg_p); end
    step(20);
    total++; if (gc_p[7:4] !== 4'd15) begin bad++; $display("FAIL perf_sat: got %0d want 15", gc_p[7:4]); end
    total++; if (gc_m[31:16] !== 16'd20) begin bad++; $display("FAIL perf_cnt: got %0d want 20", gc_m[31:16]); end
    total++; if (gc_p[3:0] !== 4'd0) begin bad++; $display("FAIL perf_idle_ch: got %0d want 0", gc_p[3:0]); end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    total++; if (gc_p[7:4] !== 4'd0) begin bad++; $display("FAIL perf_clr_p: got %0d want 0", gc_p[7:4]); end
    total++; if (gc_m[31:16] !== 16'd0) begin bad++; $display("FAIL perf_clr_m: got %0d want 0", gc_m[31:16]); end
    step(1);
    total++; if (gc_m[31:16] !== 16'd1) begin bad++; $display("FAIL perf_resume: got %0d want 1", gc_m[31:16]); end
  endtask

  task automatic test_hold0_reset();
    rst = 1'b1; act = 4'b1111;
    step(1);
    rst = 1'b0; act = 4'b1110;
    step(1);
    total++; if (cg_z !== 4'hE) begin bad++; $display("FAIL hold0_fast_gate: got %h want e", cg_z); end
    step(2);
    rst = 1'b1;
    step(1);
    total++; if (cg_z !== 4'hF || st_z !== 8'h00) begin
      bad++; $display("FAIL reset_in_gated: got cg=%h st=%h want cg=f st=00", cg_z, st_z);
    end
    total++; if (st_m !== 8'h00 || cg_m !== 4'hF) begin
      bad++; $display("FAIL reset_in_hold: got st=%h cg=%h want st=00 cg=f", st_m, cg_m);
    end
    rst = 1'b0; act = 4'hF;
    step(1);
  endtask

  initial begin
    test_reset();
    test_gate();
    test_wake();
    test_override();
    test_perf();
    test_hold0_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
